// File: rtl/uart_fb_loader_pkg.sv
// Shared constants and state encodings for the UART frame-buffer loader.
// Imported by the byte receiver and by the packet top level.
package uart_fb_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         PIX_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AH,
        ST_AL,
        ST_CH,
        ST_CL,
        ST_PH,
        ST_PL
    } fb_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, centre-sampling bit timer and shifter.
// Pulses rx_valid with rx_data on a good stop bit, rx_ferr on a low stop bit.
module uart_rx_byte
    import uart_fb_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                tick_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            // A glitch that is high again at half a bit is not a start bit.
            RX_START: begin
                if (tick_q == HALF_M1) begin
                    tick_d  = '0;
                    idx_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // The line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = data_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_fb_loader.sv
// Parses 0xA5-framed pixel packets from UART and writes RGB565 words to the frame-buffer
// write port, with an inter-byte timeout and sticky error flags.
module uart_fb_loader
    import uart_fb_loader_pkg::*;
#(
    parameter int CLK_HZ      = 27000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 14,
    parameter int FB_DEPTH    = 16200,
    parameter int TIMEOUT_CYC = 270000
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              ser_rx,
    output logic              fb_wen,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [PIX_W-1:0]  fb_wdata,
    output logic              busy,
    output logic              err_addr,
    output logic              err_timeout,
    output logic              err_frame,
    input  logic              err_clr
);

    localparam int               CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int               TMO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYC - 1);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (ser_rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    fb_state_e         state_q, state_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [7:0]        pix_hi_q, pix_hi_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              fb_wen_q, fb_wen_d;
    logic [ADDR_W-1:0] fb_waddr_q, fb_waddr_d;
    logic [PIX_W-1:0]  fb_wdata_q, fb_wdata_d;
    logic              err_addr_q, err_addr_d;
    logic              err_tmo_q, err_tmo_d;
    logic              err_frame_q, err_frame_d;
    logic              set_addr, set_tmo, tmo_hit;

    always_comb begin
        state_d    = state_q;
        addr_hi_d  = addr_hi_q;
        cnt_hi_d   = cnt_hi_q;
        pix_hi_d   = pix_hi_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        fb_wen_d   = 1'b0;
        fb_waddr_d = fb_waddr_q;
        fb_wdata_d = fb_wdata_q;
        set_addr   = 1'b0;
        set_tmo    = 1'b0;
        tmo_hit    = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
        tmo_d      = (state_q == ST_IDLE || rx_valid) ? '0 : tmo_q + TMO_W'(1);

        if (rx_valid) begin
            case (state_q)
                ST_IDLE: if (rx_data == SYNC_BYTE) state_d = ST_AH;
                ST_AH: begin
                    addr_hi_d = rx_data;
                    state_d   = ST_AL;
                end
                // A rejected start address leaves the rest of the packet to sync hunting.
                ST_AL: begin
                    if ({addr_hi_q, rx_data} >= 16'(FB_DEPTH)) begin
                        set_addr = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cur_addr_d = ADDR_W'({addr_hi_q, rx_data});
                        state_d    = ST_CH;
                    end
                end
                ST_CH: begin
                    cnt_hi_d = rx_data;
                    state_d  = ST_CL;
                end
                ST_CL: begin
                    cnt_d   = {cnt_hi_q, rx_data};
                    state_d = ({cnt_hi_q, rx_data} == 16'd0) ? ST_IDLE : ST_PH;
                end
                ST_PH: begin
                    pix_hi_d = rx_data;
                    state_d  = ST_PL;
                end
                ST_PL: begin
                    fb_wen_d   = 1'b1;
                    fb_waddr_d = cur_addr_q;
                    fb_wdata_d = {pix_hi_q, rx_data};
                    cur_addr_d = (cur_addr_q == ADDR_W'(FB_DEPTH - 1)) ? '0
                                                                      : cur_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q - 16'd1;
                    state_d    = (cnt_q == 16'd1) ? ST_IDLE : ST_PH;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (tmo_hit) begin
            set_tmo = 1'b1;
            state_d = ST_IDLE;
        end

        // A new error on the same cycle as err_clr must stay visible.
        err_addr_d  = (err_addr_q  & ~err_clr) | set_addr;
        err_tmo_d   = (err_tmo_q   & ~err_clr) | set_tmo;
        err_frame_d = (err_frame_q & ~err_clr) | rx_ferr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            addr_hi_q   <= '0;
            cnt_hi_q    <= '0;
            pix_hi_q    <= '0;
            cur_addr_q  <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            fb_wen_q    <= 1'b0;
            fb_waddr_q  <= '0;
            fb_wdata_q  <= '0;
            err_addr_q  <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_hi_q   <= addr_hi_d;
            cnt_hi_q    <= cnt_hi_d;
            pix_hi_q    <= pix_hi_d;
            cur_addr_q  <= cur_addr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            fb_wen_q    <= fb_wen_d;
            fb_waddr_q  <= fb_waddr_d;
            fb_wdata_q  <= fb_wdata_d;
            err_addr_q  <= err_addr_d;
            err_tmo_q   <= err_tmo_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign fb_wen      = fb_wen_q;
    assign fb_waddr    = fb_waddr_q;
    assign fb_wdata    = fb_wdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_addr    = err_addr_q;
    assign err_timeout = err_tmo_q;
    assign err_frame   = err_frame_q;

endmodule
